obj_oam_writer: RTL and testbench

OBJ_OAM_WRITER -- requirements
Module: obj_oam_writer

---
 rtl/obj_pkg.sv | 28 ++
 rtl/obj_write_fifo.sv | 50 +++++
 rtl/obj_oam_writer.sv | 120 ++++++++++++
 tb/tb_obj_oam_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared types for the CPU-side OAM write path: size codes, writer FSM states
// and the buffered write entry.
package obj_pkg;

   localparam int unsigned OAM_WORDS = 256;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } wr_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RDWAIT,
      ST_MERGE,
      ST_WRITE
   } wr_state_e;

   typedef struct packed {
      logic [$clog2(OAM_WORDS)-1:0] index;
      logic                         half;
      wr_size_e                     size;
      logic [31:0]                  data;
   } fifo_entry_t;

endpackage

// File: rtl/obj_write_fifo.sv
// Small FIFO of pending OAM writes; pointers carry one extra wrap bit so that
// full and empty are distinguishable. FIFO_DEPTH must be a power of two.
module obj_write_fifo
   import obj_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  fifo_entry_t push_entry,
   input  logic        pop,
   output fifo_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   fifo_entry_t mem_q [FIFO_DEPTH];
   logic        do_push, do_pop;

   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty   = (wptr_q == rptr_q);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q + {{AW{1'b0}}, do_push};
      rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/obj_oam_writer.sv
// Buffers CPU OAM writes and retires them into the shared OAM port when the
// OBJ lookup unit releases it; halfwords go through read-merge-write.
module obj_oam_writer
   import obj_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_req,
   input  logic [9:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [1:0]  wr_size,
   output logic        wr_ready,
   input  logic        lookup_busy,
   output logic [9:0]  OAMaddr_w,
   output logic        OAMre,
   output logic        OAMwe,
   output logic [31:0] OAMwdata,
   input  logic [31:0] OAMdata,
   output logic        pending
);

   wr_state_e   state_q, state_d;
   logic [31:0] merge_q, merge_d;
   fifo_entry_t push_entry, head;
   wr_size_e    size_in;
   logic        grant, push, pop, full, empty;

   assign grant    = ~lookup_busy;
   assign size_in  = wr_size_e'(wr_size);
   assign wr_ready = ~full;
   assign pending  = ~empty | (state_q != ST_IDLE);

   // Byte and reserved sizes are accepted but never buffered.
   assign push = wr_req & ~full & ~reset & ((size_in == SZ_HALF) | (size_in == SZ_WORD));

   always_comb begin
      push_entry.index = wr_addr[9:2];
      push_entry.half  = (size_in == SZ_HALF) ? wr_addr[1] : 1'b0;
      push_entry.size  = size_in;
      push_entry.data  = (size_in == SZ_HALF) ? {16'h0000, wr_data[15:0]} : wr_data;
   end

   obj_write_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );

   always_comb begin
      state_d   = state_q;
      merge_d   = merge_q;
      pop       = 1'b0;
      OAMre     = 1'b0;
      OAMwe     = 1'b0;
      OAMaddr_w = '0;
      OAMwdata  = '0;
      case (state_q)
         ST_IDLE: begin
            if (!empty && grant) begin
               OAMaddr_w = {head.index, 2'b00};
               if (head.size == SZ_WORD) begin
                  OAMwe    = 1'b1;
                  OAMwdata = head.data;
                  pop      = 1'b1;
               end else begin
                  OAMre   = 1'b1;
                  state_d = ST_RDWAIT;
               end
            end
         end
         ST_RDWAIT: begin
            merge_d = OAMdata;
            state_d = ST_MERGE;
         end
         ST_MERGE: begin
            if (head.half) merge_d[31:16] = head.data[15:0];
            else           merge_d[15:0]  = head.data[15:0];
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (grant) begin
               OAMwe     = 1'b1;
               OAMaddr_w = {head.index, 2'b00};
               OAMwdata  = merge_q;
               pop       = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Silence the port while reset is held so an in-flight RMW never writes back.
      if (reset) begin
         pop       = 1'b0;
         OAMre     = 1'b0;
         OAMwe     = 1'b0;
         OAMaddr_w = '0;
         OAMwdata  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         merge_q <= '0;
      end else begin
         state_q <= state_d;
         merge_q <= merge_d;
      end
   end

endmodule

// File: tb/tb_obj_oam_writer.sv
// Directed bench for obj_oam_writer with a behavioural OAM (one-cycle read
// latency) attached to the write port.
module tb_obj_oam_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_req;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  wr_size;
   logic        wr_ready;
   logic        lookup_busy;
   logic [9:0]  OAMaddr_w;
   logic        OAMre;
   logic        OAMwe;
   logic [31:0] OAMwdata;
   logic [31:0] OAMdata;
   logic        pending;

   logic        init_oam;
   logic [31:0] oam [256];
   int unsigned we_count;
   int unsigned viol;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   obj_oam_writer #(
      .FIFO_DEPTH (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_size     (wr_size),
      .wr_ready    (wr_ready),
      .lookup_busy (lookup_busy),
      .OAMaddr_w   (OAMaddr_w),
      .OAMre       (OAMre),
      .OAMwe       (OAMwe),
      .OAMwdata    (OAMwdata),
      .OAMdata     (OAMdata),
      .pending     (pending)
   );

   always #5 clock = ~clock;

   // OAM model plus protocol monitor (exclusive strobes, quiet when busy, zeroed bus when idle)
   always @(posedge clock) begin
      if (init_oam) begin
         for (int i = 0; i < 256; i++) oam[i] <= 32'h0;
         oam[1]   <= 32'h11112222;
         OAMdata  <= 32'h0;
         we_count <= 0;
         viol     <= 0;
      end else begin
         if (OAMre) OAMdata <= oam[OAMaddr_w[9:2]];
         if (OAMwe) begin
            oam[OAMaddr_w[9:2]] <= OAMwdata;
            we_count <= we_count + 1;
         end
         viol <= viol + 32'(OAMre && OAMwe)
                      + 32'((OAMre || OAMwe) && lookup_busy)
                      + 32'(!OAMre && !OAMwe && (OAMaddr_w != 10'h0 || OAMwdata != 32'h0));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic issue(input logic [9:0] a, input logic [31:0] d, input logic [1:0] s);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_size = s;
      nxt();
      wr_req  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned wc;
      logic        done;
      reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_size = '0;
      lookup_busy = 1'b0; init_oam = 1'b1;
      nxt(); nxt();
      init_oam = 1'b0;
      nxt();
      reset = 1'b0;

      // reset state
      mid();
      check("rst_re",    32'(OAMre), 0);
      check("rst_we",    32'(OAMwe), 0);
      check("rst_addr",  32'(OAMaddr_w), 0);
      check("rst_wdata", OAMwdata, 0);
      check("rst_pend",  32'(pending), 0);
      check("rst_ready", 32'(wr_ready), 1);

      // word write, one-cycle latency
      nxt();
      wr_req = 1'b1; wr_addr = 10'h00C; wr_data = 32'hDEADBEEF; wr_size = 2'd2;
      mid();
      check("w_n_we", 32'(OAMwe), 0);
      nxt();
      wr_req = 1'b0;
      mid();
      check("w_we",    32'(OAMwe), 1);
      check("w_re",    32'(OAMre), 0);
      check("w_addr",  32'(OAMaddr_w), 32'h00C);
      check("w_wdata", OAMwdata, 32'hDEADBEEF);
      nxt(); mid();
      check("w_pend", 32'(pending), 0);
      check("w_we2",  32'(OAMwe), 0);

      // halfword read-merge-write into upper half
      nxt();
      issue(10'h006, 32'h0000ABCD, 2'd1);
      mid();
      check("h_re1",   32'(OAMre), 1);
      check("h_addr1", 32'(OAMaddr_w), 32'h004);
      check("h_we1",   32'(OAMwe), 0);
      check("h_pend",  32'(pending), 1);
      nxt(); mid();
      check("h_re2",   32'(OAMre), 0);
      check("h_we2",   32'(OAMwe), 0);
      check("h_addr2", 32'(OAMaddr_w), 0);
      nxt(); mid();
      check("h_we3", 32'(OAMwe), 0);
      nxt(); mid();
      check("h_we4",    32'(OAMwe), 1);
      check("h_addr4",  32'(OAMaddr_w), 32'h004);
      check("h_wdata4", OAMwdata, 32'hABCD2222);
      nxt(); mid();
      check("h_pend5", 32'(pending), 0);
      check("h_oam",   oam[1], 32'hABCD2222);

      // byte write dropped
      nxt();
      issue(10'h010, 32'h00000055, 2'd0);
      mid();
      check("b_re",    32'(OAMre), 0);
      check("b_we",    32'(OAMwe), 0);
      check("b_pend",  32'(pending), 0);
      check("b_ready", 32'(wr_ready), 1);

      // fill FIFO while the lookup unit owns the port
      nxt();
      lookup_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_req = 1'b1; wr_addr = 10'(32'h040 + 4 * i); wr_data = 32'hA0000000 + 32'(i); wr_size = 2'd2;
         mid();
         check("f_ready", 32'(wr_ready), 1);
         check("f_we",    32'(OAMwe), 0);
         nxt();
      end
      wr_req = 1'b1; wr_addr = 10'h050; wr_data = 32'hCAFE0005; wr_size = 2'd2;
      mid();
      check("f_full",  32'(wr_ready), 0);
      check("f_pend",  32'(pending), 1);
      check("f_quiet", 32'(OAMwe | OAMre), 0);
      nxt();
      wr_req = 1'b0;
      lookup_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mid();
         check("d_we",    32'(OAMwe), 1);
         check("d_addr",  32'(OAMaddr_w), 32'h040 + 4 * i);
         check("d_wdata", OAMwdata, 32'hA0000000 + 32'(i));
         nxt();
      end
      mid();
      check("d_pend",  32'(pending), 0);
      check("d_we5",   32'(OAMwe), 0);
      check("d_fifth", oam[20], 0);

      // contention while in WRITE
      nxt();
      issue(10'h006, 32'h00005555, 2'd1);
      mid();
      check("c_re", 32'(OAMre), 1);
      nxt(); nxt(); nxt();
      lookup_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mid();
         check("c_hold_we", 32'(OAMwe), 0);
         check("c_hold_re", 32'(OAMre), 0);
         check("c_hold_pd", 32'(pending), 1);
         nxt();
      end
      lookup_busy = 1'b0;
      mid();
      check("c_we",    32'(OAMwe), 1);
      check("c_addr",  32'(OAMaddr_w), 32'h004);
      check("c_wdata", OAMwdata, 32'h55552222);
      nxt(); mid();
      check("c_pend", 32'(pending), 0);

      // word then halfword to the same OAM word
      nxt();
      wr_req = 1'b1; wr_addr = 10'h020; wr_data = 32'h0000FFFF; wr_size = 2'd2;
      nxt();
      wr_addr = 10'h022; wr_data = 32'h00001234; wr_size = 2'd1;
      nxt();
      wr_req = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         mid();
         if (!pending) done = 1'b1;
         else nxt();
      end
      check("o_done", 32'(done), 1);
      check("o_oam",  oam[8], 32'h1234FFFF);

      // reset while in MERGE abandons the entry
      nxt();
      issue(10'h004, 32'h00007777, 2'd1);
      mid();
      check("r_re", 32'(OAMre), 1);
      nxt(); nxt();
      reset = 1'b1;
      mid();
      check("r_we_rst", 32'(OAMwe), 0);
      check("r_re_rst", 32'(OAMre), 0);
      wc = we_count;
      nxt();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mid();
         check("r_pend",  32'(pending), 0);
         check("r_ready", 32'(wr_ready), 1);
         check("r_we",    32'(OAMwe), 0);
         nxt();
      end
      check("r_wcount", we_count, wc);
      check("r_oam",    oam[1], 32'h55552222);

      check("protocol", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
